// File: rtl/noc_pkg.sv
// Shared NoC definitions: default widths and the loader FSM encoding.
package noc_pkg;

  localparam int NOC_ADDR_W     = 14;
  localparam int NOC_OFFCHIP_DW = 512;
  localparam int NOC_RD_LAT     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/ddr_pod_loader_if.sv
// Command, DDR-read and pod-write signals of the DDR-to-pod loader.
interface ddr_pod_loader_if #(
  parameter int ADDR_W     = noc_pkg::NOC_ADDR_W,
  parameter int OFFCHIP_DW = noc_pkg::NOC_OFFCHIP_DW,
  parameter int LEN_W      = 8
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_W-1:0]     cmd_src;
  logic [ADDR_W-1:0]     cmd_dst;
  logic [LEN_W-1:0]      cmd_len;
  logic [ADDR_W-1:0]     ddr_raddr;
  logic                  ddr_ren;
  logic [OFFCHIP_DW-1:0] ddr_rdata;
  logic                  pod_wen;
  logic [ADDR_W-1:0]     pod_waddr;
  logic [OFFCHIP_DW-1:0] pod_wdata;
  logic                  busy;
  logic                  done;

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst, cmd_len, ddr_rdata,
    output cmd_ready, ddr_raddr, ddr_ren, pod_wen, pod_waddr, pod_wdata, busy, done
  );

  modport master (
    output cmd_valid, cmd_src, cmd_dst, cmd_len, ddr_rdata,
    input  cmd_ready, ddr_raddr, ddr_ren, pod_wen, pod_waddr, pod_wdata, busy, done
  );

endinterface

// File: rtl/lat_pipe.sv
// Fixed-depth valid/index delay line matching the DDR read latency.
module lat_pipe #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic             valid_reg [DEPTH];
  logic [IDX_W-1:0] idx_reg   [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          valid_reg[gi] <= rst ? 1'b0 : in_valid;
          idx_reg[gi]   <= in_idx;
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          valid_reg[gi] <= rst ? 1'b0 : valid_reg[gi-1];
          idx_reg[gi]   <= idx_reg[gi-1];
        end
      end
    end
  endgenerate

  assign out_valid = valid_reg[DEPTH-1];
  assign out_idx   = idx_reg[DEPTH-1];

endmodule

// File: rtl/ddr_pod_loader.sv
// Copies a burst of words from DDR into pod memory: issues reads, then
// writes each returned word RD_LAT+1 cycles after its read was issued.
module ddr_pod_loader
  import noc_pkg::*;
#(
  parameter int ADDR_W     = NOC_ADDR_W,
  parameter int OFFCHIP_DW = NOC_OFFCHIP_DW,
  parameter int LEN_W      = 8,
  parameter int RD_LAT     = NOC_RD_LAT
) (
  input logic             clk,
  input logic             rst,
  ddr_pod_loader_if.slave bus
);

  loader_state_e         state_reg;
  logic [ADDR_W-1:0]     dst_reg;
  logic [ADDR_W-1:0]     raddr_reg;
  logic                  ren_reg;
  logic [LEN_W-1:0]      idx_reg;
  logic [LEN_W-1:0]      issue_left_reg;
  logic [LEN_W-1:0]      write_left_reg;
  logic                  pod_wen_reg;
  logic [ADDR_W-1:0]     pod_waddr_reg;
  logic [OFFCHIP_DW-1:0] pod_wdata_reg;
  logic                  pipe_valid;
  logic [LEN_W-1:0]      pipe_idx;

  lat_pipe #(
    .DEPTH (RD_LAT),
    .IDX_W (LEN_W)
  ) u_lat_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (ren_reg),
    .in_idx    (idx_reg),
    .out_valid (pipe_valid),
    .out_idx   (pipe_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      dst_reg        <= '0;
      raddr_reg      <= '0;
      ren_reg        <= 1'b0;
      idx_reg        <= '0;
      issue_left_reg <= '0;
      write_left_reg <= '0;
      pod_wen_reg    <= 1'b0;
      pod_waddr_reg  <= '0;
      pod_wdata_reg  <= '0;
    end else begin
      // Write stage: the pipe output lines up with the DDR data of that beat.
      pod_wen_reg <= pipe_valid;
      if (pipe_valid) begin
        pod_waddr_reg <= dst_reg + ADDR_W'(pipe_idx);
        pod_wdata_reg <= bus.ddr_rdata;
      end
      if (pod_wen_reg) begin
        write_left_reg <= write_left_reg - LEN_W'(1);
      end

      case (state_reg)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            dst_reg        <= bus.cmd_dst;
            write_left_reg <= bus.cmd_len;
            if (bus.cmd_len == '0) begin
              state_reg <= ST_DONE;
            end else begin
              state_reg      <= ST_ISSUE;
              ren_reg        <= 1'b1;
              raddr_reg      <= bus.cmd_src;
              idx_reg        <= '0;
              issue_left_reg <= bus.cmd_len - LEN_W'(1);
            end
          end
        end
        ST_ISSUE: begin
          if (issue_left_reg == '0) begin
            ren_reg   <= 1'b0;
            state_reg <= ST_DRAIN;
          end else begin
            raddr_reg      <= raddr_reg + ADDR_W'(1);
            idx_reg        <= idx_reg + LEN_W'(1);
            issue_left_reg <= issue_left_reg - LEN_W'(1);
          end
        end
        ST_DRAIN: begin
          // The last write always lands after ISSUE has ended.
          if (pod_wen_reg && write_left_reg == LEN_W'(1)) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = !rst && (state_reg == ST_IDLE);
  assign bus.busy      = !rst && (state_reg != ST_IDLE);
  assign bus.done      = !rst && (state_reg == ST_DONE);
  assign bus.ddr_ren   = !rst && ren_reg;
  assign bus.ddr_raddr = rst ? '0 : raddr_reg;
  assign bus.pod_wen   = !rst && pod_wen_reg;
  assign bus.pod_waddr = rst ? '0 : pod_waddr_reg;
  assign bus.pod_wdata = rst ? '0 : pod_wdata_reg;

endmodule

// File: tb/tb_ddr_pod_loader.sv
// Directed bench for ddr_pod_loader with a read/write scoreboard and a
// latency-accurate DDR model that returns the read address as data.
module tb_ddr_pod_loader;

  localparam int ADDR_W     = 14;
  localparam int OFFCHIP_DW = 512;
  localparam int LEN_W      = 8;
  localparam int RD_LAT     = 4;

  typedef struct packed {
    logic [ADDR_W-1:0]     a;
    logic [OFFCHIP_DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [ADDR_W-1:0] rq[$];
  wr_t               wq[$];
  logic [ADDR_W-1:0] ddr_pipe [RD_LAT];

  ddr_pod_loader_if #(.ADDR_W(ADDR_W), .OFFCHIP_DW(OFFCHIP_DW), .LEN_W(LEN_W)) bus ();

  ddr_pod_loader #(
    .ADDR_W     (ADDR_W),
    .OFFCHIP_DW (OFFCHIP_DW),
    .LEN_W      (LEN_W),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // DDR model: data for an address appears RD_LAT cycles after it was presented.
  always @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) ddr_pipe[i] <= ddr_pipe[i-1];
    ddr_pipe[0] <= bus.ddr_raddr;
  end
  assign bus.ddr_rdata = OFFCHIP_DW'(ddr_pipe[RD_LAT-1]);

  task automatic chk(input string tag, input logic [OFFCHIP_DW-1:0] obs,
                     input logic [OFFCHIP_DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                          input int len);
    wr_t w;
    for (int k = 0; k < len; k++) begin
      logic [ADDR_W-1:0] ra;
      ra  = src + ADDR_W'(k);
      w.a = dst + ADDR_W'(k);
      w.d = OFFCHIP_DW'(ra);
      rq.push_back(ra);
      wq.push_back(w);
    end
  endtask

  task automatic drive_cmd(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                           input int len);
    bus.cmd_valid = 1'b1;
    bus.cmd_src   = src;
    bus.cmd_dst   = dst;
    bus.cmd_len   = LEN_W'(len);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, bus.done, 1'b1);
  endtask

  // Scoreboard side: every read strobe and write strobe pops one expectation.
  always @(negedge clk) begin
    logic [ADDR_W-1:0] ea;
    wr_t               ew;
    if (bus.ddr_ren === 1'b1) begin
      if (rq.size() == 0) chk("ddr_ren_unexpected", 1'b1, 1'b0);
      else begin
        ea = rq.pop_front();
        chk("ddr_raddr", bus.ddr_raddr, ea);
      end
    end
    if (bus.pod_wen === 1'b1) begin
      if (wq.size() == 0) chk("pod_wen_unexpected", 1'b1, 1'b0);
      else begin
        ew = wq.pop_front();
        chk("pod_waddr", bus.pod_waddr, ew.a);
        chk("pod_wdata", bus.pod_wdata, ew.d);
      end
    end
  end

  initial begin
    int n, nw, first, last;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_src   = '0;
    bus.cmd_dst   = '0;
    bus.cmd_len   = '0;
    repeat (3) tick();

    // Reset values, then ready in the first cycle out of reset.
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_ddr_ren", bus.ddr_ren, 1'b0);
    chk("rst_pod_wen", bus.pod_wen, 1'b0);
    chk("rst_pod_wdata", bus.pod_wdata, '0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", bus.cmd_ready, 1'b1);
    tick();

    // Basic burst: src 0x10, dst 0x200, len 4; exact cycle schedule.
    drive_cmd(14'h0010, 14'h0200, 4);
    push_cmd(14'h0010, 14'h0200, 4);
    chk("t1_ready", bus.cmd_ready, 1'b1);
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      chk($sformatf("t1_ren_c%0d", i), bus.ddr_ren, (i >= 1 && i <= 4));
      chk($sformatf("t1_wen_c%0d", i), bus.pod_wen, (i >= 6 && i <= 9));
      chk($sformatf("t1_done_c%0d", i), bus.done, (i == 10));
      chk($sformatf("t1_busy_c%0d", i), bus.busy, (i <= 10));
      tick();
    end

    // Zero-length command.
    drive_cmd(14'h0055, 14'h0066, 0);
    tick();
    bus.cmd_valid = 1'b0;
    chk("t2_done", bus.done, 1'b1);
    chk("t2_ren", bus.ddr_ren, 1'b0);
    chk("t2_wen", bus.pod_wen, 1'b0);
    chk("t2_ready_low", bus.cmd_ready, 1'b0);
    tick();
    chk("t2_ready_again", bus.cmd_ready, 1'b1);
    chk("t2_done_low", bus.done, 1'b0);

    // Address wrap-around on both sides.
    drive_cmd(14'h3FFE, 14'h3FFF, 3);
    push_cmd(14'h3FFE, 14'h3FFF, 3);
    tick();
    bus.cmd_valid = 1'b0;
    wait_done("t3_done_timeout", 40);
    tick();

    // Reset one cycle at T+3 of a len=8 burst aborts it.
    drive_cmd(14'h0400, 14'h0800, 8);
    push_cmd(14'h0400, 14'h0800, 8);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    rq.delete();
    wq.delete();
    #1;
    chk("t4_rst_ren", bus.ddr_ren, 1'b0);
    chk("t4_rst_wen", bus.pod_wen, 1'b0);
    chk("t4_rst_busy", bus.busy, 1'b0);
    chk("t4_rst_ready", bus.cmd_ready, 1'b0);
    chk("t4_rst_raddr", bus.ddr_raddr, '0);
    chk("t4_rst_waddr", bus.pod_waddr, '0);
    tick();
    rst = 1'b0;
    #1;
    chk("t4_ready_after", bus.cmd_ready, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk("t4_no_wen", bus.pod_wen, 1'b0);
      chk("t4_no_done", bus.done, 1'b0);
      tick();
    end

    // Second command held pending during a burst.
    drive_cmd(14'h0100, 14'h0050, 3);
    push_cmd(14'h0100, 14'h0050, 3);
    tick();
    drive_cmd(14'h1234, 14'h2000, 2);
    push_cmd(14'h1234, 14'h2000, 2);
    chk("t5_ready_busy", bus.cmd_ready, 1'b0);
    wait_done("t5_a_done_timeout", 40);
    chk("t5_ready_at_done", bus.cmd_ready, 1'b0);
    tick();
    chk("t5_ready_after_done", bus.cmd_ready, 1'b1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("t5_b_busy", bus.busy, 1'b1);
    chk("t5_b_ren", bus.ddr_ren, 1'b1);
    wait_done("t5_b_done_timeout", 40);
    tick();

    // Maximum length burst: 255 gap-free writes and one done pulse.
    drive_cmd(14'h0123, 14'h3F80, 255);
    push_cmd(14'h0123, 14'h3F80, 255);
    tick();
    bus.cmd_valid = 1'b0;
    n = 0; nw = 0; first = -1; last = -1;
    while (bus.done !== 1'b1 && n < 400) begin
      if (bus.pod_wen === 1'b1) begin
        if (first < 0) first = n;
        last = n;
        nw++;
      end
      tick();
      n++;
    end
    chk("t6_done_timeout", bus.done, 1'b1);
    chk("t6_write_count", nw, 255);
    chk("t6_gap_free", last - first + 1, 255);
    chk("t6_done_after_last", n, last + 1);
    tick();
    chk("t6_done_single", bus.done, 1'b0);
    chk("t6_ready", bus.cmd_ready, 1'b1);

    chk("sb_reads_left", rq.size(), 0);
    chk("sb_writes_left", wq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr_pod_loader.md
DDR_POD_LOADER -- requirements
Module: ddr_pod_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning DDR and pod-memory word address width.
REQ-002 SHALL have parameter OFFCHIP_DW, default 512, meaning level-1 data width.
REQ-003 SHALL have parameter LEN_W, default 8, meaning burst-length field width.
REQ-004 SHALL have parameter RD_LAT, default 4 (>=1), meaning fixed DDR read latency in cycles.
REQ-005 SHALL have port clk, input, width 1: clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, width 1: reset, synchronous, active-high.
REQ-007 SHALL have port cmd_valid, input, width 1: load command present.
REQ-008 SHALL have port cmd_ready, output, width 1: block accepts a command this cycle.
REQ-009 SHALL have port cmd_src, input, width ADDR_W: DDR start word address.
REQ-010 SHALL have port cmd_dst, input, width ADDR_W: pod-memory start word address.
REQ-011 SHALL have port cmd_len, input, width LEN_W: beat count; 0 is legal.
REQ-012 SHALL have port ddr_raddr, output, width ADDR_W: DDR read address.
REQ-013 SHALL have port ddr_ren, output, width 1: ddr_raddr valid this cycle.
REQ-014 SHALL have port ddr_rdata, input, width OFFCHIP_DW: DDR read data, RD_LAT cycles after the address.
REQ-015 SHALL have port pod_wen, output, width 1: pod write strobe.
REQ-016 SHALL have port pod_waddr, output, width ADDR_W: pod write address.
REQ-017 SHALL have port pod_wdata, output, width OFFCHIP_DW: pod write data.
REQ-018 SHALL have port busy, output, width 1: high in any state except IDLE.
REQ-019 SHALL have port done, output, width 1: one-cycle completion pulse.

Function
REQ-020 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-021 SHALL drive cmd_ready=1 only in IDLE; acceptance is cmd_valid&&cmd_ready, after which src, dst and len are latched.
REQ-022 On acceptance with len>0, SHALL enter ISSUE; with len=0, SHALL go directly to DONE with no ddr_ren and no pod_wen.
REQ-023 In ISSUE, SHALL assert ddr_ren with registered ddr_raddr=src+k for k=0..len-1 on consecutive cycles; the first issue is the cycle after acceptance.
REQ-024 After the last issue, SHALL enter DRAIN and stay there until the last write has occurred.
REQ-025 SHALL delay each issue through an RD_LAT-deep valid/index shift pipe; for beat k issued at cycle t, SHALL assert pod_wen at t+RD_LAT+1 with pod_wdata=ddr_rdata sampled at t+RD_LAT and pod_waddr=dst+k.
REQ-026 Writes SHALL be gap-free and in order, exactly len per command.
REQ-027 SHALL compute all address arithmetic modulo 2^ADDR_W; wrap-around past all-ones is legal and silent.
REQ-028 SHALL pulse done for exactly one cycle in DONE, i.e. the cycle after the final pod_wen (or the cycle after acceptance when len=0), then return to IDLE.
REQ-029 SHALL ignore cmd_valid outside IDLE; a new command is accepted no earlier than the cycle after done.
REQ-030 SHALL hold ddr_raddr, pod_waddr and pod_wdata stable when their strobe is low; their values are don't-care except at reset.
REQ-031 SHALL support cmd_len=2^LEN_W-1 without counter overflow.

Reset
REQ-032 While rst is high, SHALL force state=IDLE, clear the shift pipe, and drive ddr_ren=0, pod_wen=0, done=0, busy=0, cmd_ready=0, ddr_raddr=0, pod_waddr=0, pod_wdata=0.
REQ-033 An rst asserted mid-burst SHALL abort the burst: no pod_wen from in-flight beats after rst, and no done pulse.
REQ-034 SHALL drive cmd_ready=1 in the first cycle after rst deasserts.

Structure
REQ-035 SHALL take the FSM state enum and the default ADDR_W, OFFCHIP_DW and RD_LAT values from the shared noc_pkg package.
REQ-036 SHALL place the RD_LAT-deep valid/index delay line in one sub-module, lat_pipe.

Verification
REQ-037 Bench SHALL cover: src=0x0010, dst=0x0200, len=4, RD_LAT=4, DDR model returning data=address -> ddr_ren at cycles T+1..T+4; pod_wen at T+6..T+9 with (waddr, wdata) = (0x200,0x10)..(0x203,0x13); done at T+10.
REQ-038 Bench SHALL cover: len=0 -> no ddr_ren and no pod_wen; done at T+1; cmd_ready high again at T+2.
REQ-039 Bench SHALL cover: src=0x3FFE, dst=0x3FFF, len=3 -> raddr sequence 3FFE, 3FFF, 0000; waddr sequence 3FFF, 0000, 0001.
REQ-040 Bench SHALL cover: rst pulsed one cycle at T+3 during a len=8 burst -> no pod_wen and no done afterwards; all outputs at reset values; cmd_ready=1 the cycle after rst drops.
REQ-041 Bench SHALL cover: cmd_valid held high with a second command pending during a burst -> second command accepted the cycle after done, with no overlap of pod_wen between the two bursts.
REQ-042 Bench SHALL cover: len=255 -> exactly 255 gap-free writes, then a single done pulse.
